shift_pattern_gen: RTL and testbench

SHIFT_PATTERN_GEN -- requirements
Module: shift_pattern_gen

---
 rtl/shift_pattern_gen.sv | 93 +++++++++
 tb/tb_shift_pattern_gen.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_pattern_gen.sv
// Shift/rotate pattern generator: a start in IDLE launches a run, and the first beat appears one cycle later.
// Backpressure: out_valid and out_data hold while out_ready is low. A beat occurs on each cycle with valid and ready both high.
module shift_pattern_gen #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] seed,
  input  logic             dir,
  input  logic             rotate,
  input  logic             abort,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             done,
  output logic [7:0]       step_cnt
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EMIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             dir_q;
  logic             rotate_q;
  logic [WIDTH-1:0] seed_eff;
  logic [WIDTH-1:0] next_pat;
  logic [7:0]       step_inc;
  logic             beat;
  logic             last_beat;

  // An all-zero seed would end a logical run immediately, so it is promoted to 1.
  assign seed_eff = (seed == '0) ? WIDTH'(1) : seed;

  always_comb begin
    next_pat = '0;
    if (rotate_q) begin
      if (dir_q) next_pat = (out_data >> 1) | (out_data << (WIDTH - 1));
      else       next_pat = (out_data << 1) | (out_data >> (WIDTH - 1));
    end else begin
      if (dir_q) next_pat = out_data >> 1;
      else       next_pat = out_data << 1;
    end
  end

  assign step_inc  = (step_cnt == 8'hFF) ? 8'hFF : step_cnt + 8'd1;
  assign beat      = (state == ST_EMIT) && out_ready;
  assign last_beat = beat && (rotate_q ? ((int'(step_cnt) + 1) >= WIDTH)
                                       : (next_pat == '0));

  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE: state_nxt = start ? ST_EMIT : ST_IDLE;
      ST_EMIT: begin
        if (abort)          state_nxt = ST_IDLE;
        else if (last_beat) state_nxt = ST_DONE;
        else                state_nxt = ST_EMIT;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      dir_q    <= 1'b0;
      rotate_q <= 1'b0;
      out_data <= '0;
      step_cnt <= 8'd0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && start) begin
        dir_q    <= dir;
        rotate_q <= rotate;
        out_data <= seed_eff;
        step_cnt <= 8'd0;
      end else if (beat) begin
        out_data <= next_pat;
        step_cnt <= step_inc;
      end
    end
  end

  assign out_valid = (state == ST_EMIT);
  assign busy      = (state == ST_EMIT);
  assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_shift_pattern_gen.sv
// Directed bench for shift_pattern_gen: stimulus queues expected beats and run lengths, and a monitor checks them.
module tb_shift_pattern_gen;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] seed;
  logic         dir;
  logic         rotate;
  logic         abort;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         busy;
  logic         done;
  logic [7:0]   step_cnt;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] beat_q[$];
  int           cnt_q[$];

  shift_pattern_gen #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .seed(seed), .dir(dir), .rotate(rotate),
    .abort(abort), .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .busy(busy), .done(done), .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_beats(input int n, input logic [W-1:0] v0, input logic [W-1:0] v1,
                              input logic [W-1:0] v2, input logic [W-1:0] v3);
    if (n > 0) beat_q.push_back(v0);
    if (n > 1) beat_q.push_back(v1);
    if (n > 2) beat_q.push_back(v2);
    if (n > 3) beat_q.push_back(v3);
  endtask

  // Start pulse for one cycle, then verify the first beat appears on the next cycle.
  task automatic start_run(input logic [W-1:0] s, input logic d, input logic r,
                           input logic [W-1:0] first);
    @(posedge clk); #1;
    start = 1'b1; seed = s; dir = d; rotate = r;
    @(posedge clk); #1;
    start = 1'b0;
    chk("latency_valid", {31'd0, out_valid}, 32'd1);
    chk("latency_data", {28'd0, out_data}, {28'd0, first});
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy || done) && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy || done) begin
      errors++;
      $display("FAIL %s: timeout waiting for idle, busy=%0b done=%0b", name, busy, done);
    end
  endtask

  // Monitor: beats and done pulses are compared against the queued expectations.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid || done)
        chk("done_with_valid", {31'd0, done & out_valid}, 32'd0);
      if (out_valid && out_ready) begin
        if (beat_q.size() == 0) begin
          chk("unexpected_beat", {28'd0, out_data}, 32'hFFFF_FFFF);
        end else begin
          logic [W-1:0] e;
          e = beat_q.pop_front();
          chk("beat_data", {28'd0, out_data}, {28'd0, e});
        end
      end
      if (done) begin
        if (cnt_q.size() == 0) begin
          chk("unexpected_done", {31'd0, done}, 32'd0);
        end else begin
          int c;
          c = cnt_q.pop_front();
          chk("done_step_cnt", {24'd0, step_cnt}, c);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; start = 1'b0; seed = '0; dir = 1'b0; rotate = 1'b0;
    abort = 1'b0; out_ready = 1'b1;
    #2;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_data", {28'd0, out_data}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_step", {24'd0, step_cnt}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Left logical walking one
    expect_beats(4, 4'h1, 4'h2, 4'h4, 4'h8); cnt_q.push_back(4);
    start_run(4'h1, 1'b0, 1'b0, 4'h1);
    wait_idle("run_0001");
    chk("hold_step_0001", {24'd0, step_cnt}, 32'd4);
    chk("hold_data_0001", {28'd0, out_data}, 32'd0);

    // Right rotate; after the 4th beat the pattern has wrapped back to 1000
    expect_beats(4, 4'h8, 4'h4, 4'h2, 4'h1); cnt_q.push_back(4);
    start_run(4'h8, 1'b1, 1'b1, 4'h8);
    wait_idle("run_rot_r");
    chk("hold_data_rot", {28'd0, out_data}, 32'h8);

    expect_beats(4, 4'h3, 4'h6, 4'hC, 4'h8); cnt_q.push_back(4);
    start_run(4'h3, 1'b0, 1'b0, 4'h3);
    wait_idle("run_0011");

    // Backpressure: stall on the second beat for three cycles
    expect_beats(3, 4'h2, 4'h4, 4'h8, 4'h0); cnt_q.push_back(3);
    start_run(4'h2, 1'b0, 1'b0, 4'h2);
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_data", {28'd0, out_data}, 32'h4);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    wait_idle("run_stall");

    // Zero seed behaves like 0001
    expect_beats(4, 4'h1, 4'h2, 4'h4, 4'h8); cnt_q.push_back(4);
    start_run(4'h0, 1'b0, 1'b0, 4'h1);
    wait_idle("run_zero");

    // Abort on the 2nd beat; a start issued during EMIT must not relaunch
    expect_beats(2, 4'h1, 4'h2, 4'h0, 4'h0);
    start_run(4'h1, 1'b0, 1'b0, 4'h1);
    @(posedge clk); #1;
    abort = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    chk("abort_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_step", {24'd0, step_cnt}, 32'd2);
    chk("abort_data", {28'd0, out_data}, 32'h4);
    @(posedge clk); @(posedge clk); #1;
    chk("abort_idle", {31'd0, out_valid | busy | done}, 32'd0);

    // Abort coincides with the last beat: abort wins
    expect_beats(1, 4'h8, 4'h0, 4'h0, 4'h0);
    start_run(4'h8, 1'b0, 1'b0, 4'h8);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_last_done", {31'd0, done}, 32'd0);
    chk("abort_last_step", {24'd0, step_cnt}, 32'd1);
    @(posedge clk); #1;

    // Start during the DONE cycle is not queued
    expect_beats(1, 4'h8, 4'h0, 4'h0, 4'h0); cnt_q.push_back(1);
    start_run(4'h8, 1'b0, 1'b0, 4'h8);
    @(posedge clk); #1;
    chk("done_pulse", {31'd0, done}, 32'd1);
    start = 1'b1; seed = 4'h5;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_in_done_ignored", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("start_in_done_still_idle", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset between edges mid-run
    expect_beats(1, 4'h1, 4'h0, 4'h0, 4'h0);
    start_run(4'h1, 1'b0, 1'b0, 4'h1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_data", {28'd0, out_data}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_done", {31'd0, done}, 32'd0);
    chk("arst_step", {24'd0, step_cnt}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_rst_idle", {31'd0, out_valid | done}, 32'd0);
    end

    // Left rotate after reset needs a fresh start
    expect_beats(4, 4'h1, 4'h2, 4'h4, 4'h8); cnt_q.push_back(4);
    start_run(4'h1, 1'b0, 1'b1, 4'h1);
    wait_idle("run_rot_l");
    chk("rot_l_wrap", {28'd0, out_data}, 32'h1);

    repeat (2) @(posedge clk);
    #1;
    chk("beats_left", beat_q.size(), 32'd0);
    chk("dones_left", cnt_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
